// File: rtl/cei_mochila_pkg.sv
// Shared crossbar constants plus the error-slave log state and defaults.
package cei_mochila_pkg;

  localparam int unsigned SYSTEM_XBAR_NMASTER     = 5;
  localparam int unsigned LOG_SYSTEM_XBAR_NMASTER = 3;

  localparam logic [31:0] ERROR_RDATA_DEFAULT = 32'hBADACCE5;
  localparam int unsigned ERR_CNT_WIDTH       = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    CAPTURED = 2'd1,
    OVERFLOW = 2'd2
  } err_log_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear in the same cycle as inc restarts at 1.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic             at_max;

  assign at_max = &cnt_q;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && !at_max) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/system_bus_error_slave.sv
// Crossbar default slave: answers every access with an OBI error response,
// logs the first fault, counts all faults and raises a sticky interrupt.
module system_bus_error_slave
  import cei_mochila_pkg::*;
#(
  parameter logic [31:0] ERROR_RDATA = ERROR_RDATA_DEFAULT,
  parameter int unsigned CNT_WIDTH   = ERR_CNT_WIDTH,
  parameter int unsigned NMASTER     = SYSTEM_XBAR_NMASTER,
  parameter int unsigned MIDX_WIDTH  = LOG_SYSTEM_XBAR_NMASTER
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [MIDX_WIDTH-1:0] midx_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  input  logic                  clear_i,
  output logic                  irq_o,
  output logic                  log_valid_o,
  output logic                  log_overflow_o,
  output logic [31:0]           log_addr_o,
  output logic                  log_we_o,
  output logic [MIDX_WIDTH-1:0] log_midx_o,
  output logic [CNT_WIDTH-1:0]  fault_cnt_o
);

  logic                  accept;
  logic                  rvalid_q, rd_q, irq_q;
  err_log_state_e        state_q;
  logic [31:0]           log_addr_q;
  logic                  log_we_q;
  logic [MIDX_WIDTH-1:0] log_midx_q;

  // Write data and byte enables carry no information for an error response.
  logic unused_ok;
  assign unused_ok = ^{be_i, wdata_i, 32'(NMASTER)};

  assign gnt_o  = req_i;
  assign accept = req_i & gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      rvalid_q <= accept;
      rd_q     <= accept & ~we_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = rvalid_q;
  assign rdata_o  = rd_q ? ERROR_RDATA : 32'h0;

  // A clear coinciding with an accept restarts the log on that access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      log_addr_q <= '0;
      log_we_q   <= 1'b0;
      log_midx_q <= '0;
    end else if (accept) begin
      if (clear_i || state_q == EMPTY) begin
        state_q    <= CAPTURED;
        log_addr_q <= addr_i;
        log_we_q   <= we_i;
        log_midx_q <= midx_i;
      end else begin
        state_q <= OVERFLOW;
      end
    end else if (clear_i) begin
      state_q    <= EMPTY;
      log_addr_q <= '0;
      log_we_q   <= 1'b0;
      log_midx_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                irq_q <= 1'b0;
    else if (accept)            irq_q <= 1'b1;
    else if (clear_i)           irq_q <= 1'b0;
  end

  assign irq_o          = irq_q;
  assign log_valid_o    = (state_q != EMPTY);
  assign log_overflow_o = (state_q == OVERFLOW);
  assign log_addr_o     = log_addr_q;
  assign log_we_o       = log_we_q;
  assign log_midx_o     = log_midx_q;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_fault_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (accept),
    .clr_i  (clear_i),
    .cnt_o  (fault_cnt_o)
  );

endmodule
